// File: rtl/mips_pkg.sv
// mips_pkg: shared widths and the decoded-control bundle for the MIPS-style pipeline.
//   REG_W      register-number width
//   ALUOP_W    ALU operation width
//   DEF_DATA_W default datapath width for register data and immediates
//   ctrl_t     control signals carried alongside an instruction through ID/EX
package mips_pkg;

    localparam int unsigned REG_W      = 5;
    localparam int unsigned ALUOP_W    = 4;
    localparam int unsigned DEF_DATA_W = 32;

    typedef struct packed {
        logic               regwrite;
        logic               memread;
        logic               memwrite;
        logic               memtoreg;
        logic               alusrc;
        logic [ALUOP_W-1:0] aluop;
    } ctrl_t;

endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: combinational load-use hazard check between the load sitting in ID/EX
// and the instruction currently being decoded in ID.
//   id_ex_valid, id_ex_memread, id_ex_rt  in   state of the instruction in ID/EX
//   if_id_rs, if_id_rt                    in   source registers of the instruction in ID
//   load_use                              out  the ID instruction needs the load result
module hazard_detect
    import mips_pkg::*;
(
    input  logic             id_ex_valid,
    input  logic             id_ex_memread,
    input  logic [REG_W-1:0] id_ex_rt,
    input  logic [REG_W-1:0] if_id_rs,
    input  logic [REG_W-1:0] if_id_rt,
    output logic             load_use
);

    // $zero is hardwired, so a load targeting it never produces a value worth waiting for.
    always_comb begin
        load_use = id_ex_valid & id_ex_memread & (id_ex_rt != '0) &
                   ((id_ex_rt == if_id_rs) | (id_ex_rt == if_id_rt));
    end

endmodule

// File: rtl/id_ex_pipe.sv
// id_ex_pipe: ID/EX pipeline register with load-use stall and branch-flush bubbles.
//   clk, rst                    clock, asynchronous active-high reset
//   flush                       redirect from EX; squashes the instruction entering ID/EX
//   if_id_rs/rt, id_rd          register numbers from ID
//   id_rs_data/rt_data/imm      operands from ID
//   id_regwrite..id_aluop       decoded control from ID
//   id_ex_*                     registered copies of the above, id_ex_valid = not a bubble
//   pc_write, if_id_write       combinational; low freezes PC and IF/ID for a stall
//   stall_cnt                   saturating count of load-use stall cycles
// Build option: define HAZARD_DETECT_EN to enable load-use stalling and the stall counter.
// Without it the pipe never stalls and stall_cnt reads 0.
module id_ex_pipe
    import mips_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned CNT_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic [REG_W-1:0]   if_id_rs,
    input  logic [REG_W-1:0]   if_id_rt,
    input  logic [REG_W-1:0]   id_rd,
    input  logic [DATA_W-1:0]  id_rs_data,
    input  logic [DATA_W-1:0]  id_rt_data,
    input  logic [DATA_W-1:0]  id_imm,
    input  logic               id_regwrite,
    input  logic               id_memread,
    input  logic               id_memwrite,
    input  logic               id_memtoreg,
    input  logic               id_alusrc,
    input  logic [ALUOP_W-1:0] id_aluop,
    output logic [REG_W-1:0]   id_ex_rs,
    output logic [REG_W-1:0]   id_ex_rt,
    output logic [REG_W-1:0]   id_ex_rd,
    output logic [DATA_W-1:0]  id_ex_rs_data,
    output logic [DATA_W-1:0]  id_ex_rt_data,
    output logic [DATA_W-1:0]  id_ex_imm,
    output logic               id_ex_regwrite,
    output logic               id_ex_memread,
    output logic               id_ex_memwrite,
    output logic               id_ex_memtoreg,
    output logic               id_ex_alusrc,
    output logic [ALUOP_W-1:0] id_ex_aluop,
    output logic               id_ex_valid,
    output logic               pc_write,
    output logic               if_id_write,
    output logic [CNT_W-1:0]   stall_cnt
);

    logic [REG_W-1:0]  rs_q, rt_q, rd_q;
    logic [DATA_W-1:0] rs_data_q, rt_data_q, imm_q;
    ctrl_t             ctrl_q;
    ctrl_t             id_ctrl;
    logic              valid_q;
    logic              load_use;
    logic              stall;
    logic              bubble;

    always_comb begin
        id_ctrl.regwrite = id_regwrite;
        id_ctrl.memread  = id_memread;
        id_ctrl.memwrite = id_memwrite;
        id_ctrl.memtoreg = id_memtoreg;
        id_ctrl.alusrc   = id_alusrc;
        id_ctrl.aluop    = id_aluop;
    end

`ifdef HAZARD_DETECT_EN
    logic [CNT_W-1:0] stall_cnt_q;

    hazard_detect u_hazard_detect (
        .id_ex_valid   (valid_q),
        .id_ex_memread (ctrl_q.memread),
        .id_ex_rt      (rt_q),
        .if_id_rs      (if_id_rs),
        .if_id_rt      (if_id_rt),
        .load_use      (load_use)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    logic unused_hazard_inputs;

    assign unused_hazard_inputs = ^{if_id_rs, if_id_rt};
    assign load_use             = 1'b0;
    assign stall_cnt            = '0;
`endif

    // Flush wins: the redirected path must keep fetching even if the squashed
    // instruction would have waited on the load.
    always_comb begin
        stall       = load_use & ~flush;
        bubble      = stall | flush;
        pc_write    = ~stall;
        if_id_write = ~stall;
    end

    // Operand fields load unconditionally; only control and valid are zeroed for a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rs_q      <= '0;
            rt_q      <= '0;
            rd_q      <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
            ctrl_q    <= '0;
            valid_q   <= 1'b0;
        end else begin
            rs_q      <= if_id_rs;
            rt_q      <= if_id_rt;
            rd_q      <= id_rd;
            rs_data_q <= id_rs_data;
            rt_data_q <= id_rt_data;
            imm_q     <= id_imm;
            ctrl_q    <= bubble ? ctrl_t'('0) : id_ctrl;
            valid_q   <= ~bubble;
        end
    end

    assign id_ex_rs       = rs_q;
    assign id_ex_rt       = rt_q;
    assign id_ex_rd       = rd_q;
    assign id_ex_rs_data  = rs_data_q;
    assign id_ex_rt_data  = rt_data_q;
    assign id_ex_imm      = imm_q;
    assign id_ex_regwrite = ctrl_q.regwrite;
    assign id_ex_memread  = ctrl_q.memread;
    assign id_ex_memwrite = ctrl_q.memwrite;
    assign id_ex_memtoreg = ctrl_q.memtoreg;
    assign id_ex_alusrc   = ctrl_q.alusrc;
    assign id_ex_aluop    = ctrl_q.aluop;
    assign id_ex_valid    = valid_q;

endmodule

// File: tb/tb_id_ex_pipe.sv
// tb_id_ex_pipe: directed and random checks of id_ex_pipe against a reference model.
// Counter width is reduced so saturation is reachable in a short run.
module tb_id_ex_pipe;
    import mips_pkg::*;

    localparam int unsigned DW    = 32;
    localparam int unsigned CW    = 8;
    localparam int          CMAX  = (1 << CW) - 1;
`ifdef HAZARD_DETECT_EN
    localparam bit          HAZ_EN = 1'b1;
`else
    localparam bit          HAZ_EN = 1'b0;
`endif

    typedef struct {
        logic           flush;
        logic [4:0]     rs, rt, rd;
        logic [DW-1:0]  rsd, rtd, imm;
        logic           rw, mr, mw, m2r, asrc;
        logic [3:0]     aluop;
    } instr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush;
    logic [4:0] if_id_rs, if_id_rt, id_rd;
    logic [DW-1:0] id_rs_data, id_rt_data, id_imm;
    logic id_regwrite, id_memread, id_memwrite, id_memtoreg, id_alusrc;
    logic [3:0] id_aluop;
    logic [4:0] id_ex_rs, id_ex_rt, id_ex_rd;
    logic [DW-1:0] id_ex_rs_data, id_ex_rt_data, id_ex_imm;
    logic id_ex_regwrite, id_ex_memread, id_ex_memwrite, id_ex_memtoreg, id_ex_alusrc;
    logic [3:0] id_ex_aluop;
    logic id_ex_valid, pc_write, if_id_write;
    logic [CW-1:0] stall_cnt;

    int total = 0;
    int bad   = 0;

    // Reference state: what the ID/EX stage should hold, plus the stall tally.
    instr_t m_held;
    logic   m_valid;
    int     m_cnt;

    always #5 clk = ~clk;

    id_ex_pipe #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .if_id_rs       (if_id_rs),
        .if_id_rt       (if_id_rt),
        .id_rd          (id_rd),
        .id_rs_data     (id_rs_data),
        .id_rt_data     (id_rt_data),
        .id_imm         (id_imm),
        .id_regwrite    (id_regwrite),
        .id_memread     (id_memread),
        .id_memwrite    (id_memwrite),
        .id_memtoreg    (id_memtoreg),
        .id_alusrc      (id_alusrc),
        .id_aluop       (id_aluop),
        .id_ex_rs       (id_ex_rs),
        .id_ex_rt       (id_ex_rt),
        .id_ex_rd       (id_ex_rd),
        .id_ex_rs_data  (id_ex_rs_data),
        .id_ex_rt_data  (id_ex_rt_data),
        .id_ex_imm      (id_ex_imm),
        .id_ex_regwrite (id_ex_regwrite),
        .id_ex_memread  (id_ex_memread),
        .id_ex_memwrite (id_ex_memwrite),
        .id_ex_memtoreg (id_ex_memtoreg),
        .id_ex_alusrc   (id_ex_alusrc),
        .id_ex_aluop    (id_ex_aluop),
        .id_ex_valid    (id_ex_valid),
        .pc_write       (pc_write),
        .if_id_write    (if_id_write),
        .stall_cnt      (stall_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic instr_t nop();
        instr_t x;
        x = '{flush: 1'b0, rs: 5'd0, rt: 5'd0, rd: 5'd0, rsd: '0, rtd: '0, imm: '0,
              rw: 1'b0, mr: 1'b0, mw: 1'b0, m2r: 1'b0, asrc: 1'b0, aluop: 4'd0};
        return x;
    endfunction

    function automatic instr_t rand_instr();
        instr_t x;
        x.flush = ($urandom_range(0, 7) == 0);
        x.rs    = 5'($urandom_range(0, 3));
        x.rt    = 5'($urandom_range(0, 3));
        x.rd    = 5'($urandom);
        x.rsd   = $urandom;
        x.rtd   = $urandom;
        x.imm   = $urandom;
        x.rw    = 1'($urandom);
        x.mr    = ($urandom_range(0, 1) == 0);
        x.mw    = 1'($urandom);
        x.m2r   = 1'($urandom);
        x.asrc  = 1'($urandom);
        x.aluop = 4'($urandom);
        return x;
    endfunction

    // The decoding instruction must wait when the valid load ahead of it writes a
    // nonzero register it reads; a redirect overrides the wait.
    function automatic bit model_stall(instr_t x);
        bit needs;
        needs = m_valid && m_held.mr && (m_held.rt != 5'd0) &&
                (m_held.rt == x.rs || m_held.rt == x.rt);
        return HAZ_EN && needs && !x.flush;
    endfunction

    task automatic model_reset();
        m_held  = nop();
        m_valid = 1'b0;
        m_cnt   = 0;
    endtask

    task automatic model_edge(input instr_t x);
        bit squash;
        squash = model_stall(x) || x.flush;
        if (model_stall(x) && m_cnt < CMAX) m_cnt++;
        m_held = x;
        if (squash) begin
            m_held.rw = 1'b0; m_held.mr = 1'b0; m_held.mw = 1'b0;
            m_held.m2r = 1'b0; m_held.asrc = 1'b0; m_held.aluop = 4'd0;
        end
        m_valid = !squash;
    endtask

    task automatic drive(input instr_t x);
        flush       = x.flush;
        if_id_rs    = x.rs;
        if_id_rt    = x.rt;
        id_rd       = x.rd;
        id_rs_data  = x.rsd;
        id_rt_data  = x.rtd;
        id_imm      = x.imm;
        id_regwrite = x.rw;
        id_memread  = x.mr;
        id_memwrite = x.mw;
        id_memtoreg = x.m2r;
        id_alusrc   = x.asrc;
        id_aluop    = x.aluop;
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".valid"}, 64'(id_ex_valid), 64'(m_valid));
        chk({tag, ".ctrl"},
            64'({id_ex_regwrite, id_ex_memread, id_ex_memwrite, id_ex_memtoreg,
                 id_ex_alusrc, id_ex_aluop}),
            64'({m_held.rw, m_held.mr, m_held.mw, m_held.m2r, m_held.asrc, m_held.aluop}));
        chk({tag, ".regs"}, 64'({id_ex_rs, id_ex_rt, id_ex_rd}),
            64'({m_held.rs, m_held.rt, m_held.rd}));
        chk({tag, ".rs_data"}, 64'(id_ex_rs_data), 64'(m_held.rsd));
        chk({tag, ".rt_data"}, 64'(id_ex_rt_data), 64'(m_held.rtd));
        chk({tag, ".imm"}, 64'(id_ex_imm), 64'(m_held.imm));
        chk({tag, ".stall_cnt"}, 64'(stall_cnt), 64'(m_cnt));
    endtask

    // One pipeline cycle: present x, check the freeze signals, clock, check the stage.
    task automatic step(input string tag, input instr_t x);
        @(negedge clk);
        drive(x);
        #1;
        chk({tag, ".pc_write"}, 64'(pc_write), 64'(!model_stall(x)));
        chk({tag, ".if_id_write"}, 64'(if_id_write), 64'(!model_stall(x)));
        @(posedge clk);
        model_edge(x);
        #1;
        check_state(tag);
    endtask

    instr_t lw5, use5, add_i, lw0, use0;

    initial begin
        model_reset();
        drive(nop());
        #2;
        check_state("reset");
        chk("reset.pc_write", 64'(pc_write), 64'd1);
        chk("reset.if_id_write", 64'(if_id_write), 64'd1);
        @(negedge clk);
        rst = 1'b0;

        // add r7, r3, r4
        add_i = nop();
        add_i.rs = 5'd3; add_i.rt = 5'd4; add_i.rd = 5'd7; add_i.rw = 1'b1;
        add_i.rsd = 32'h0000_0011; add_i.rtd = 32'h0000_0022; add_i.aluop = 4'd2;
        step("add", add_i);
        chk("add.rd_const", 64'(id_ex_rd), 64'd7);
        chk("add.rs_data_const", 64'(id_ex_rs_data), 64'h11);

        // lw r5 followed by a reader of r5
        lw5 = nop();
        lw5.rs = 5'd1; lw5.rt = 5'd5; lw5.rd = 5'd5; lw5.mr = 1'b1; lw5.m2r = 1'b1;
        lw5.rw = 1'b1; lw5.asrc = 1'b1; lw5.imm = 32'h10;
        use5 = nop();
        use5.rs = 5'd5; use5.rt = 5'd2; use5.rd = 5'd9; use5.rw = 1'b1; use5.aluop = 4'd2;
        step("lw5", lw5);
        step("use5.stall", use5);
        step("use5.retry", use5);

        // same pair, redirected
        step("lw5b", lw5);
        use5.flush = 1'b1;
        step("use5.flush", use5);
        use5.flush = 1'b0;

        // lw r0 never stalls
        lw0 = lw5; lw0.rt = 5'd0; lw0.rd = 5'd0;
        use0 = use5; use0.rs = 5'd6; use0.rt = 5'd0;
        step("lw0", lw0);
        step("use0", use0);

        for (int i = 0; i < 300; i++) step("rand", rand_instr());

        // drive the counter into saturation and beyond
        for (int i = 0; i < CMAX + 3; i++) begin
            step("sat.lw", lw5);
            step("sat.use", use5);
        end

        // reset in the middle of a stall
        step("mid.lw", lw5);
        @(negedge clk);
        drive(use5);
        #1;
        chk("mid.pc_write_pre", 64'(pc_write), 64'(!model_stall(use5)));
        rst = 1'b1;
        #1;
        model_reset();
        check_state("mid.rst");
        chk("mid.rst.pc_write", 64'(pc_write), 64'd1);
        chk("mid.rst.if_id_write", 64'(if_id_write), 64'd1);
        #1;
        rst = 1'b0;
        @(posedge clk);
        model_edge(use5);
        #1;
        check_state("mid.after");
        chk("mid.after.valid_const", 64'(id_ex_valid), 64'd1);

        for (int i = 0; i < 50; i++) step("rand2", rand_instr());

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/id_ex_pipe.md
ID_EX_PIPE -- requirements
Module: id_ex_pipe

Interface
REQ-001 DATA_W, 32, datapath width; SHALL apply to all register-data and immediate ports.
REQ-002 CNT_W, 16, stall-counter width.
REQ-003 clk  in  1  rising-edge clock; single clock domain.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 flush  in  1  branch/jump redirect from EX; squashes the instruction entering ID/EX.
REQ-006 if_id_rs, if_id_rt  in  5 each  source register numbers of the instruction in ID.
REQ-007 id_rd  in  5  destination register selected in ID (rd or rt per RegDst).
REQ-008 id_rs_data, id_rt_data, id_imm  in  DATA_W each  register-file reads and sign-extended immediate.
REQ-009 id_regwrite, id_memread, id_memwrite, id_memtoreg, id_alusrc  in  1 each  decoded control.
REQ-010 id_aluop  in  4  decoded ALU operation.
REQ-011 id_ex_rs, id_ex_rt, id_ex_rd  out  5 each  registered register numbers; rs/rt feed the EX forwarding logic.
REQ-012 id_ex_rs_data, id_ex_rt_data, id_ex_imm  out  DATA_W each  registered operands.
REQ-013 id_ex_regwrite, id_ex_memread, id_ex_memwrite, id_ex_memtoreg, id_ex_alusrc  out  1 each; id_ex_aluop  out  4  registered control.
REQ-014 id_ex_valid  out  1  high when ID/EX holds a real instruction, low for a bubble.
REQ-015 pc_write, if_id_write  out  1 each  combinational; low freezes PC and IF/ID.
REQ-016 stall_cnt  out  CNT_W  count of load-use stall cycles.

Function
REQ-017 Load-use hazard SHALL be: id_ex_valid & id_ex_memread & (id_ex_rt != 0) & (id_ex_rt == if_id_rs | id_ex_rt == if_id_rt).
REQ-018 On hazard with flush low: pc_write = if_id_write = 0 in the same cycle; next edge loads a bubble into ID/EX.
REQ-019 Bubble SHALL be: all six control outputs 0, id_ex_valid 0; register numbers, data and immediate loaded from inputs (don't-care contents, but deterministic).
REQ-020 On flush: next edge loads a bubble; pc_write = if_id_write = 1 regardless of hazard; flush has priority over stall.
REQ-021 Otherwise, every edge SHALL load all ID inputs into ID/EX with id_ex_valid = 1; latency exactly one cycle.
REQ-022 A stall SHALL last exactly one cycle per load-use pair: the inserted bubble clears id_ex_valid, so the hazard deasserts next cycle.
REQ-023 stall_cnt SHALL increment by 1 on every edge where a stall (REQ-018) applied; saturates at 2^CNT_W-1, never wraps.
REQ-024 Register 0 as id_ex_rt SHALL never cause a stall, even with memread set.

Reset
REQ-025 While rst high: all registered outputs 0, id_ex_valid 0, stall_cnt 0; pc_write = if_id_write = 1.
REQ-026 Reset asserted mid-stall SHALL abort the stall immediately (asynchronously); first edge after release behaves per REQ-021.

Configuration
REQ-027 Macro HAZARD_DETECT_EN: defined -> REQ-017/018/022/023 active.
REQ-028 Without HAZARD_DETECT_EN: no stall ever; pc_write = if_id_write = 1 constant; stall_cnt constant 0; flush behaviour unchanged.

Structure
REQ-029 Shared package mips_pkg SHALL hold REG_W (5), ALUOP_W (4), DATA_W default and a control-bundle struct typedef.
REQ-030 Hazard comparison SHALL live in one sub-module hazard_detect (combinational, instantiated only under HAZARD_DETECT_EN); registers stay in id_ex_pipe.

Verification
REQ-031 lw r5 in ID/EX (memread=1, rt=5), if_id_rs=5 -> pc_write=0, if_id_write=0; next cycle id_ex_valid=0, controls 0, stall_cnt=1; following cycle no stall.
REQ-032 Same as REQ-031 but flush=1 -> pc_write=1, bubble loaded, stall_cnt stays 0.
REQ-033 lw r0 (rt=0) in ID/EX, if_id_rt=0 -> no stall, next edge loads ID inputs with id_ex_valid=1.
REQ-034 add in ID (rs=3, rt=4, rd=7, regwrite=1, rs_data=0x0000_0011) -> after one edge id_ex_rd=7, id_ex_rs_data=0x11, id_ex_regwrite=1, id_ex_valid=1.
REQ-035 stall_cnt preset by 65535 stalls -> further stall leaves 0xFFFF; rst pulse mid-stall -> all outputs 0, pc_write=1 immediately.
REQ-036 Build without HAZARD_DETECT_EN, repeat REQ-031 -> pc_write stays 1, no bubble, stall_cnt 0.
